// File: rtl/rr_mux_reg.sv
// rr_mux_reg: registered N-to-1 channel multiplexer with valid/ready on every
// input and on the output. Two selection modes:
//   mode=0  fixed select: channel 'sel' is the only candidate.
//   mode=1  round-robin: search starts one past the last served channel.
// One beat per cycle throughput, one cycle latency.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_data    packed channel data, channel k at [k*bit_size +: bit_size]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit high)
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel select used when mode=0
//   out_data   registered data of the last accepted beat
//   out_ch     registered index of the channel that supplied out_data
//   out_valid  registered output valid
//   out_ready  consumer ready

// Per-channel slice: decides whether this channel is the granted one, drives
// its ready, and contributes its data to the OR-reduced output mux.
module rr_mux_reg_lane #(
    parameter int bit_size = 16,
    parameter int sel_w    = 2,
    parameter int lane     = 0
) (
    input  logic                rst,
    input  logic                load,
    input  logic                gnt_vld,
    input  logic [sel_w-1:0]    gnt_idx,
    input  logic [bit_size-1:0] ch_data,
    output logic                ready,
    output logic [bit_size-1:0] data_sel
);
    localparam logic [sel_w-1:0] LANE_ID = sel_w'(lane);

    logic hit;

    assign hit      = gnt_vld && (gnt_idx == LANE_ID);
    // Nothing is acknowledged while reset is held.
    assign ready    = rst && load && hit;
    // Non-granted lanes contribute zero so the top can simply OR all lanes.
    assign data_sel = hit ? ch_data : '0;
endmodule

module rr_mux_reg #(
    parameter int bit_size = 16,
    parameter int num_ch   = 4,
    parameter int sel_w    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [num_ch*bit_size-1:0] in_data,
    input  logic [num_ch-1:0]          in_valid,
    output logic [num_ch-1:0]          in_ready,
    input  logic                       mode,
    input  logic [sel_w-1:0]           sel,
    output logic [bit_size-1:0]        out_data,
    output logic [sel_w-1:0]           out_ch,
    output logic                       out_valid,
    input  logic                       out_ready
);
    localparam logic [sel_w-1:0] LAST_CH = sel_w'(num_ch - 1);

    logic [bit_size-1:0] out_data_q, out_data_d;
    logic [sel_w-1:0]    out_ch_q, out_ch_d;
    logic                out_valid_q, out_valid_d;
    logic [sel_w-1:0]    last_gnt_q, last_gnt_d;

    logic                load;
    logic                fix_vld;
    logic                hi_vld, lo_vld;
    logic [sel_w-1:0]    hi_idx, lo_idx;
    logic                gnt_vld;
    logic [sel_w-1:0]    gnt_idx;
    logic [bit_size-1:0] mux_data;

    logic [num_ch-1:0][bit_size-1:0] lane_data;

    // Output register can take a new beat when empty or being drained.
    assign load = !out_valid_q || out_ready;

    // Fixed select: only the addressed channel is considered. A select at or
    // beyond num_ch matches no lane and therefore never grants.
    always_comb begin
        fix_vld = 1'b0;
        for (int k = 0; k < num_ch; k++) begin
            if ((sel == sel_w'(k)) && in_valid[k]) begin
                fix_vld = 1'b1;
            end
        end
    end

    // Round-robin: lowest valid channel above last_gnt wins; if none exists
    // the search wraps and the lowest valid channel overall wins. Scanning
    // downward lets the last assignment be the lowest index.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int k = num_ch - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                lo_vld = 1'b1;
                lo_idx = sel_w'(k);
                if (k > int'(last_gnt_q)) begin
                    hi_vld = 1'b1;
                    hi_idx = sel_w'(k);
                end
            end
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (!mode) begin
            gnt_vld = fix_vld;
            gnt_idx = sel;
        end else if (hi_vld) begin
            gnt_vld = 1'b1;
            gnt_idx = hi_idx;
        end else begin
            gnt_vld = lo_vld;
            gnt_idx = lo_idx;
        end
    end

    for (genvar k = 0; k < num_ch; k++) begin : g_lane
        rr_mux_reg_lane #(
            .bit_size (bit_size),
            .sel_w    (sel_w),
            .lane     (k)
        ) u_lane (
            .rst      (rst),
            .load     (load),
            .gnt_vld  (gnt_vld),
            .gnt_idx  (gnt_idx),
            .ch_data  (in_data[k*bit_size +: bit_size]),
            .ready    (in_ready[k]),
            .data_sel (lane_data[k])
        );
    end

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < num_ch; k++) begin
            mux_data = mux_data | lane_data[k];
        end
    end

    // A grant with load high is exactly an input transfer. With load high and
    // no grant the register drains; data/channel keep their old values.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        last_gnt_d  = last_gnt_q;
        if (load) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = mux_data;
                out_ch_d   = gnt_idx;
                last_gnt_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            last_gnt_q  <= LAST_CH;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            last_gnt_q  <= last_gnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_mux_reg.sv
module tb_rr_mux_reg;
    logic        clk;
    logic        rst;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [47:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [15:0] out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    rr_mux_reg #(.bit_size(16), .num_ch(4), .sel_w(2)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    rr_mux_reg #(.bit_size(16), .num_ch(3), .sel_w(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] d;
        logic [1:0]  ch;
    } beat_t;

    beat_t       sbq[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    bit          mv     = 1'b0;   // model: output register holds a beat
    int          mlast  = 3;      // model: last served channel
    logic [15:0] dv[4];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    // Grant rule straight from the behaviour description: -1 means no grant.
    function automatic int model_gnt(bit m, int s, logic [3:0] v, int last);
        if (!m) return (s < 4 && v[s]) ? s : -1;
        for (int i = 1; i <= 4; i++) begin
            int c;
            c = (last + i) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One cycle of stimulus on the 4-channel DUT; predicts ready and the
    // beat that will be captured at the coming edge.
    task automatic step(input bit m, input logic [1:0] s, input logic [3:0] v, input bit ordy);
        int         g;
        bit         ld;
        logic [3:0] er;
        @(negedge clk);
        mode = m; sel = s; in_valid = v; out_ready = ordy;
        for (int k = 0; k < 4; k++) in_data[k*16 +: 16] = dv[k];
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
        ld = !mv || ordy;
        g  = model_gnt(m, int'(s), v, mlast);
        er = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("in_ready", {28'd0, in_ready}, {28'd0, er});
        if (ld) begin
            if (g >= 0) begin
                sbq.push_back('{dv[g], 2'(g)});
                mv    = 1'b1;
                mlast = g;
            end else begin
                mv = 1'b0;
            end
        end
    endtask

    // Monitor: every output handshake pops the oldest predicted beat.
    always @(negedge clk) begin
        #2;
        if (rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_beat", {16'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                beat_t b;
                b = sbq.pop_front();
                chk("sb_out_data", {16'd0, out_data}, {16'd0, b.d});
                chk("sb_out_ch", {30'd0, out_ch}, {30'd0, b.ch});
            end
        end
    end

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;
        in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;
        for (int k = 0; k < 4; k++) dv[k] = 16'h000A + 16'(k);

        // Asynchronous reset: outputs clear with no clock edge in between.
        #2 rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
        chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'd0, 4'b0000, 1'b1);
            chk("idle_out_data", {16'd0, out_data}, 32'd0);
        end

        // 3-channel instance: sel=3 never grants, round-robin wraps at 2.
        @(negedge clk);
        for (int k = 0; k < 3; k++) in_data3[k*16 +: 16] = 16'h0100 + 16'(k);
        in_valid3 = 3'b111; mode3 = 1'b0; sel3 = 2'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("n3_sel3_ready", {29'd0, in_ready3}, 32'd0);
            chk("n3_sel3_valid", {31'd0, out_valid3}, 32'd0);
            @(negedge clk);
        end
        mode3 = 1'b1;
        #1 chk("n3_rr_first_ready", {29'd0, in_ready3}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("n3_rr_valid", {31'd0, out_valid3}, 32'd1);
            chk("n3_rr_ch", {30'd0, out_ch3}, 32'(i % 3));
            chk("n3_rr_data", {16'd0, out_data3}, 32'h0100 + 32'(i % 3));
        end
        in_valid3 = 3'b000;

        // Fixed select, then re-select.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd2, 4'b1111, 1'b1);
            chk("fix_ready_ch2", {28'd0, in_ready}, 32'b0100);
        end
        chk("fix_data_ch2", {16'd0, out_data}, 32'h000C);
        chk("fix_ch_ch2", {30'd0, out_ch}, 32'd2);
        step(1'b0, 2'd3, 4'b1111, 1'b1);
        step(1'b0, 2'd3, 4'b1111, 1'b1);
        chk("fix_data_ch3", {16'd0, out_data}, 32'h000D);

        // Mode switch after serving ch2: round-robin continues at ch3.
        step(1'b0, 2'd2, 4'b1111, 1'b1);
        step(1'b0, 2'd2, 4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'd0, 4'b1111, 1'b1);
            chk("rr_all_ready", {28'd0, in_ready}, 32'(1 << ((3 + i) % 4)));
        end
        // Last served is ch2 here; only ch1/ch3 requesting alternates 3,1,...
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd0, 4'b1010, 1'b1);
            chk("rr_13_ready", {28'd0, in_ready}, (i % 2 == 0) ? 32'b1000 : 32'b0010);
        end

        // Backpressure hold.
        dv[0] = 16'h1234;
        step(1'b1, 2'd0, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd0, 4'b0001, 1'b0);
            chk("stall_data", {16'd0, out_data}, 32'h1234);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_ready", {28'd0, in_ready}, 32'd0);
        end
        step(1'b1, 2'd0, 4'b0001, 1'b1);
        chk("release_ready", {28'd0, in_ready}, 32'b0001);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) dv[k] = 16'($urandom);
            step(1'($urandom), 2'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
        end

        // Reset in the middle of a held beat.
        step(1'b1, 2'd0, 4'b1111, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        #1 chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {16'd0, out_data}, 32'd0);
        chk("mid_rst_ch", {30'd0, out_ch}, 32'd0);
        sbq.delete();
        mv = 1'b0;
        mlast = 3;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 chk("in_rst_ready", {28'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        rst = 1'b1;

        // After reset, channel 0 has top round-robin priority again.
        step(1'b1, 2'd0, 4'b1111, 1'b1);
        chk("post_rst_rr_ready", {28'd0, in_ready}, 32'b0001);

        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 4; k++) dv[k] = 16'($urandom);
            step(1'($urandom), 2'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
        end

        repeat (3) step(1'b0, 2'd0, 4'b0000, 1'b1);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
